// File: rtl/matdet_pkg.sv
// rtl/matdet_pkg.sv - shared state encoding and matrix bus width for the determinant scheduler
package matdet_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MATRIX_SIZE = 3;
    localparam int MAT_W           = DEF_MATRIX_SIZE * DEF_MATRIX_SIZE * DEF_DATA_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Flattened NxN matrix width for an arbitrary parameterisation.
    function automatic int mat_width(input int n, input int dw);
        return n * n * dw;
    endfunction

endpackage

// File: rtl/matdet_sched_if.sv
// rtl/matdet_sched_if.sv - requester, response and datapath signals of the determinant scheduler
interface matdet_sched_if
    import matdet_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MATRIX_SIZE = 3,
    parameter int N_REQ       = 4
);
    localparam int MW = mat_width(MATRIX_SIZE, DATA_WIDTH);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*MW-1:0]    req_matrix;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [MW-1:0]          det_matrix;
    logic [DATA_WIDTH-1:0]  det_result;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_det;
    logic                   rsp_singular;

    // Requesters plus the external datapath.
    modport master (
        output req, req_matrix, rsp_ready, det_result,
        input  gnt, busy, det_matrix, rsp_valid, rsp_det, rsp_singular
    );

    // The scheduler itself.
    modport slave (
        input  req, req_matrix, rsp_ready, det_result,
        output gnt, busy, det_matrix, rsp_valid, rsp_det, rsp_singular
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int          sum;
    logic [W-1:0] j;

    // First set request bit at or above ptr, wrapping back to 0.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = 0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            j = W'(sum);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/matdet_sched.sv
// rtl/matdet_sched.sv - round-robin scheduler sharing one multicycle determinant datapath
module matdet_sched
    import matdet_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BIN_POS       = 16,
    parameter int MATRIX_SIZE   = 3,
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    matdet_sched_if.slave    bus
);

    localparam int MW    = mat_width(MATRIX_SIZE, DATA_WIDTH);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // The binary point only matters to whoever interprets the values.
    if (BIN_POS < 0 || BIN_POS > DATA_WIDTH) begin : g_bad_bin_pos
        $error("matdet_sched: BIN_POS outside 0..DATA_WIDTH");
    end
    if (N_REQ < 2 || SETTLE_CYCLES < 1) begin : g_bad_cfg
        $error("matdet_sched: need N_REQ >= 2 and SETTLE_CYCLES >= 1");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] ptr;

    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_any;

    logic [MW-1:0]    req_mats [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign req_mats[g] = bus.req_matrix[g*MW +: MW];
    end

    rr_arbiter #(
        .N (N_REQ),
        .W (PTR_W)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign bus.busy = (state != ST_IDLE);

    // Capture winner, hold the matrix while the datapath settles, then hand the result back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            owner            <= '0;
            ptr              <= '0;
            bus.gnt          <= '0;
            bus.det_matrix   <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_det      <= '0;
            bus.rsp_singular <= 1'b0;
        end else begin
            bus.gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        bus.det_matrix <= req_mats[arb_idx];
                        owner          <= arb_idx;
                        bus.gnt        <= arb_gnt;
                        ptr            <= (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        cnt            <= CNT_W'(SETTLE_CYCLES - 1);
                        state          <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        bus.rsp_det      <= bus.det_result;
                        bus.rsp_singular <= (bus.det_result == '0);
                        bus.rsp_valid    <= N_REQ'(1) << owner;
                        state            <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        bus.rsp_valid <= '0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
